dlsc_stereobm_postprocess_bestsad: RTL and testbench

Streaming best-disparity tracker. Sits directly upstream of the sub-pixel postprocess stage. It consumes one SAD value per accepted cycle, disparity 0 first through DISPARITIES-1 last, for each pixel. It emits the winning disparity together with its SAD and the SADs of its two neighbours (lo = disp-1, hi = disp+1), which the sub-pixel stage needs for its interpolation.

---
 rtl/dlsc_stereobm_postprocess_bestsad.sv | 128 ++++++++++++
 tb/tb_dlsc_stereobm_postprocess_bestsad.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dlsc_stereobm_postprocess_bestsad.sv
// Streaming best-disparity tracker: finds the minimum-SAD disparity of each pixel
// and emits it with its own SAD and the SADs of both neighbouring disparities.
module dlsc_stereobm_postprocess_bestsad #(
    parameter int DISP_BITS   = 6,
    parameter int DISPARITIES = 2**DISP_BITS,
    parameter int SAD_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SAD_BITS-1:0]  in_sad,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DISP_BITS-1:0] out_disp,
    output logic [SAD_BITS-1:0]  out_sad,
    output logic [SAD_BITS-1:0]  out_lo,
    output logic [SAD_BITS-1:0]  out_hi
);

    localparam logic [DISP_BITS-1:0] LAST_DISP = DISP_BITS'(DISPARITIES - 1);

    logic [DISP_BITS-1:0] d_q, d_d;
    logic [DISP_BITS-1:0] best_disp_q, best_disp_d;
    logic [SAD_BITS-1:0]  best_sad_q, best_sad_d;
    logic [SAD_BITS-1:0]  best_lo_q, best_lo_d;
    logic [SAD_BITS-1:0]  best_hi_q, best_hi_d;
    logic [SAD_BITS-1:0]  prev_sad_q, prev_sad_d;
    logic                 hi_pend_q, hi_pend_d;

    logic                 out_valid_q, out_valid_d;
    logic [DISP_BITS-1:0] out_disp_q, out_disp_d;
    logic [SAD_BITS-1:0]  out_sad_q, out_sad_d;
    logic [SAD_BITS-1:0]  out_lo_q, out_lo_d;
    logic [SAD_BITS-1:0]  out_hi_q, out_hi_d;

    logic accept;
    logic is_last;
    logic new_best;

    // The output register is a one-deep skid: it may be refilled in the cycle it is taken.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_last  = (d_q == LAST_DISP);
    assign new_best = (d_q == '0) || (in_sad < best_sad_q);

    always_comb begin
        d_d         = d_q;
        best_disp_d = best_disp_q;
        best_sad_d  = best_sad_q;
        best_lo_d   = best_lo_q;
        best_hi_d   = best_hi_q;
        prev_sad_d  = prev_sad_q;
        hi_pend_d   = hi_pend_q;
        out_valid_d = out_valid_q;
        out_disp_d  = out_disp_q;
        out_sad_d   = out_sad_q;
        out_lo_d    = out_lo_q;
        out_hi_d    = out_hi_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            d_d        = is_last ? '0 : d_q + 1'b1;
            prev_sad_d = in_sad;
            if (new_best) begin
                best_sad_d  = in_sad;
                best_disp_d = d_q;
                best_lo_d   = (d_q == '0) ? in_sad : prev_sad_q;
                hi_pend_d   = 1'b1;
            end else if (hi_pend_q) begin
                best_hi_d = in_sad;
                hi_pend_d = 1'b0;
            end

            // Results come from the next-state values so the last sample is included;
            // a winner at the last disparity has no upper neighbour and reuses its own SAD.
            if (is_last) begin
                out_valid_d = 1'b1;
                out_disp_d  = best_disp_d;
                out_sad_d   = best_sad_d;
                out_lo_d    = best_lo_d;
                out_hi_d    = hi_pend_d ? in_sad : best_hi_d;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q         <= '0;
            best_disp_q <= '0;
            best_sad_q  <= '0;
            best_lo_q   <= '0;
            best_hi_q   <= '0;
            prev_sad_q  <= '0;
            hi_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_disp_q  <= '0;
            out_sad_q   <= '0;
            out_lo_q    <= '0;
            out_hi_q    <= '0;
        end else begin
            d_q         <= d_d;
            best_disp_q <= best_disp_d;
            best_sad_q  <= best_sad_d;
            best_lo_q   <= best_lo_d;
            best_hi_q   <= best_hi_d;
            prev_sad_q  <= prev_sad_d;
            hi_pend_q   <= hi_pend_d;
            out_valid_q <= out_valid_d;
            out_disp_q  <= out_disp_d;
            out_sad_q   <= out_sad_d;
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_disp  = out_disp_q;
    assign out_sad   = out_sad_q;
    assign out_lo    = out_lo_q;
    assign out_hi    = out_hi_q;

endmodule

// File: tb/tb_dlsc_stereobm_postprocess_bestsad.sv
// Directed bench for the best-disparity tracker: a 4-disparity instance for the
// main cases and a 3-disparity instance for counter wrap.
module tb_dlsc_stereobm_postprocess_bestsad;

    localparam int DB = 2;
    localparam int SB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [SB-1:0] in_sad = '0, out_sad, out_lo, out_hi;
    logic [DB-1:0] out_disp;

    logic          in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b1;
    logic [SB-1:0] in_sad3 = '0, out_sad3, out_lo3, out_hi3;
    logic [DB-1:0] out_disp3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dlsc_stereobm_postprocess_bestsad #(.DISP_BITS(DB), .DISPARITIES(4), .SAD_BITS(SB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sad(in_sad),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_disp(out_disp), .out_sad(out_sad), .out_lo(out_lo), .out_hi(out_hi)
    );

    dlsc_stereobm_postprocess_bestsad #(.DISP_BITS(DB), .DISPARITIES(3), .SAD_BITS(SB)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_sad(in_sad3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_disp(out_disp3), .out_sad(out_sad3), .out_lo(out_lo3), .out_hi(out_hi3)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offers one sample to the 4-disparity instance, waiting (bounded) for in_ready.
    task automatic push(input int s);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sad   = SB'(s);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic push4(input int a, input int b, input int c, input int e);
        push(a); push(b); push(c); push(e);
    endtask

    // Checks the result visible after the last accept, then that it was held for one cycle only.
    task automatic check_px(input string tag, input int disp, input int sad, input int lo, input int hi);
        @(negedge clk);
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_disp"},  int'(out_disp),  disp);
        chk({tag, "_sad"},   int'(out_sad),   sad);
        chk({tag, "_lo"},    int'(out_lo),    lo);
        chk({tag, "_hi"},    int'(out_hi),    hi);
        @(negedge clk);
        chk({tag, "_drop"},  int'(out_valid), 0);
    endtask

    task automatic push3(input int s);
        @(negedge clk);
        in_valid3 = 1'b1;
        in_sad3   = SB'(s);
        @(posedge clk);
        #1 in_valid3 = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ready", int'(in_ready),  1);
        chk("rst_disp",  int'(out_disp),  0);
        chk("rst_sad",   int'(out_sad),   0);
        chk("rst_lo",    int'(out_lo),    0);
        chk("rst_hi",    int'(out_hi),    0);

        push4(10, 5, 7, 9);  check_px("basic",   1, 5, 10, 7);
        push4(3, 8, 8, 8);   check_px("first",   0, 3, 3, 8);
        push4(9, 9, 9, 2);   check_px("last",    3, 2, 9, 2);
        push4(9, 9, 1, 4);   check_px("penult",  2, 1, 9, 4);
        push4(6, 4, 4, 5);   check_px("tie",     1, 4, 6, 4);
        push4(7, 7, 7, 7);   check_px("alleq",   0, 7, 7, 7);

        // Backpressure: first result held while the next pixel's first sample waits.
        out_ready = 1'b0;
        push4(10, 5, 7, 9);
        @(negedge clk);
        in_valid = 1'b1;
        in_sad   = SB'(9);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", int'(in_ready),  0);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_disp",  int'(out_disp),  1);
            chk("bp_sad",   int'(out_sad),   5);
            chk("bp_lo",    int'(out_lo),    10);
            chk("bp_hi",    int'(out_hi),    7);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_taken", int'(out_valid), 0);
        push(9); push(1); push(4);
        check_px("bp_second", 2, 1, 9, 4);

        // Reset mid-pixel discards partial state.
        push(1); push(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push4(10, 5, 7, 9);
        check_px("rst_mid", 1, 5, 10, 7);

        // Three-disparity instance, two pixels to exercise the counter wrap.
        for (int p = 0; p < 2; p++) begin
            push3(4); push3(2); push3(1);
            @(negedge clk);
            chk("d3_valid", int'(out_valid3), 1);
            chk("d3_disp",  int'(out_disp3),  2);
            chk("d3_sad",   int'(out_sad3),   1);
            chk("d3_lo",    int'(out_lo3),    2);
            chk("d3_hi",    int'(out_hi3),    1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
